// File: rtl/calc_entry_seq_if.sv
// ----------------------------------------------------------------------------
// calc_entry_seq_if
// Bundles the key strobe, the result handshake and the registered operand
// outputs of the keypad-entry sequencer.
//   master : key source / arithmetic side (drives keys and result_ack)
//   slave  : the sequencer (drives operands, op, counts, state, req, err)
// Parameter DIGITS sets BCD digits per operand; CW is derived from it.
// ----------------------------------------------------------------------------
interface calc_entry_seq_if #(
    parameter int DIGITS = 2
);
    localparam int CW = $clog2(DIGITS + 1);

    logic                  key_valid;
    logic [4:0]            key_code;
    logic                  result_ack;
    logic [4*DIGITS-1:0]   operand_a;
    logic [4*DIGITS-1:0]   operand_b;
    logic [1:0]            op;
    logic [CW-1:0]         digits_a;
    logic [CW-1:0]         digits_b;
    logic [2:0]            state;
    logic                  result_req;
    logic                  key_err;

    modport master (
        output key_valid, key_code, result_ack,
        input  operand_a, operand_b, op, digits_a, digits_b,
               state, result_req, key_err
    );

    modport slave (
        input  key_valid, key_code, result_ack,
        output operand_a, operand_b, op, digits_a, digits_b,
               state, result_req, key_err
    );
endinterface

// File: rtl/calc_entry_seq.sv
// ----------------------------------------------------------------------------
// calc_entry_seq
// Keypad-entry sequencer: turns one-cycle key strobes into registered BCD
// operands A and B, an operator code and a result request with a
// request/acknowledge handshake.
// Ports:
//   clk     : system clock, all state changes on its rising edge
//   reset_n : synchronous active-low reset
//   bus     : calc_entry_seq_if.slave (key_valid/key_code/result_ack in,
//             operand_a/operand_b/op/digits_a/digits_b/state/result_req/
//             key_err out; all outputs registered)
// Optional feature: define CALC_BACKSPACE_EN to make key 17 a backspace;
// otherwise key 17 is an illegal key.
// ----------------------------------------------------------------------------
module calc_entry_seq #(
    parameter int DIGITS = 2,
    parameter int CW     = $clog2(DIGITS + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    calc_entry_seq_if.slave bus
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [2:0] {
        ENTER_A = 3'b000,
        WAIT_OP = 3'b001,
        ENTER_B = 3'b010,
        RESULT  = 3'b011
    } state_t;

    state_t         state_r;
    logic [W-1:0]   opa_r;
    logic [W-1:0]   opb_r;
    logic [1:0]     op_r;
    logic [CW-1:0]  cnt_a_r;
    logic [CW-1:0]  cnt_b_r;
    logic           req_r;
    logic           err_r;
    logic           fresh_r;

    logic           is_digit_s;
    logic           is_op_s;
    logic           is_enter_s;
    logic           is_clear_s;
    logic           is_bs_s;
    logic [3:0]     digit_s;
    logic [1:0]     op_code_s;

    // Shift an operand left one nibble, newest digit into the low nibble.
    function automatic logic [W-1:0] push_digit(input logic [W-1:0] v,
                                                input logic [3:0]   d);
        logic [W+3:0] t;
        t = {v, d};
        return t[W-1:0];
    endfunction

    // Drop the newest digit, zero-filling the top nibble.
    function automatic logic [W-1:0] pop_digit(input logic [W-1:0] v);
        return v >> 4;
    endfunction

    // Key decode; codes outside every class are illegal.
    always_comb begin
        is_digit_s = (bus.key_code >= 5'd1) && (bus.key_code <= 5'd10);
        digit_s    = (bus.key_code == 5'd10) ? 4'd0 : bus.key_code[3:0];
        is_op_s    = (bus.key_code >= 5'd11) && (bus.key_code <= 5'd14);
        // key_code - 11 for codes 11..14, taken from the low two bits
        op_code_s  = bus.key_code[1:0] + 2'd1;
        is_enter_s = (bus.key_code == 5'd15);
        is_clear_s = (bus.key_code == 5'd16);
`ifdef CALC_BACKSPACE_EN
        is_bs_s    = (bus.key_code == 5'd17);
`else
        is_bs_s    = 1'b0;
`endif
    end

    // Sequencer state, operands and handshake outputs.
    always_ff @(posedge clk) begin
        if (!reset_n || (bus.key_valid && is_clear_s)) begin
            state_r <= ENTER_A;
            opa_r   <= {W{1'b0}};
            opb_r   <= {W{1'b0}};
            op_r    <= 2'd0;
            cnt_a_r <= {CW{1'b0}};
            cnt_b_r <= {CW{1'b0}};
            req_r   <= 1'b0;
            err_r   <= 1'b0;
            fresh_r <= 1'b0;
        end else begin
            err_r <= 1'b0;
            if (state_r == RESULT && bus.result_ack) begin
                state_r <= ENTER_A;
                req_r   <= 1'b0;
                fresh_r <= 1'b1;
            end
            if (bus.key_valid) begin
                case (state_r)
                    ENTER_A: begin
                        if (fresh_r) begin
                            // First digit after a result starts a new calculation.
                            if (is_digit_s) begin
                                opa_r   <= push_digit({W{1'b0}}, digit_s);
                                cnt_a_r <= CW'(1);
                                opb_r   <= {W{1'b0}};
                                cnt_b_r <= {CW{1'b0}};
                                op_r    <= 2'd0;
                                fresh_r <= 1'b0;
                                state_r <= (DIGITS == 1) ? WAIT_OP : ENTER_A;
                            end else begin
                                err_r <= 1'b1;
                            end
                        end else if (is_digit_s) begin
                            opa_r   <= push_digit(opa_r, digit_s);
                            cnt_a_r <= cnt_a_r + CW'(1);
                            if (cnt_a_r == CW'(DIGITS - 1)) begin
                                state_r <= WAIT_OP;
                            end
                        end else if (is_op_s && cnt_a_r != CW'(0)) begin
                            op_r    <= op_code_s;
                            state_r <= ENTER_B;
                        end else if (is_bs_s && cnt_a_r != CW'(0)) begin
                            opa_r   <= pop_digit(opa_r);
                            cnt_a_r <= cnt_a_r - CW'(1);
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                    WAIT_OP: begin
                        if (is_op_s) begin
                            op_r    <= op_code_s;
                            state_r <= ENTER_B;
                        end else if (is_bs_s) begin
                            opa_r   <= pop_digit(opa_r);
                            cnt_a_r <= cnt_a_r - CW'(1);
                            state_r <= ENTER_A;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                    ENTER_B: begin
                        if (is_digit_s && cnt_b_r != CW'(DIGITS)) begin
                            opb_r   <= push_digit(opb_r, digit_s);
                            cnt_b_r <= cnt_b_r + CW'(1);
                        end else if (is_enter_s && cnt_b_r != CW'(0)) begin
                            state_r <= RESULT;
                            req_r   <= 1'b1;
                        end else if (is_bs_s && cnt_b_r != CW'(0)) begin
                            opb_r   <= pop_digit(opb_r);
                            cnt_b_r <= cnt_b_r - CW'(1);
                        end else if (is_bs_s) begin
                            // Backing out of an empty B withdraws the operator.
                            op_r    <= 2'd0;
                            state_r <= WAIT_OP;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                    RESULT: begin
                        // Clear is handled above; everything else is rejected.
                        err_r <= 1'b1;
                    end
                    default: begin
                        state_r <= ENTER_A;
                        err_r   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.operand_a  = opa_r;
    assign bus.operand_b  = opb_r;
    assign bus.op         = op_r;
    assign bus.digits_a   = cnt_a_r;
    assign bus.digits_b   = cnt_b_r;
    assign bus.state      = state_r;
    assign bus.result_req = req_r;
    assign bus.key_err    = err_r;
endmodule

// File: tb/tb_calc_entry_seq.sv
// ----------------------------------------------------------------------------
// tb_calc_entry_seq
// Directed key sequences for calc_entry_seq with DIGITS = 2. Each stimulus
// step pushes the hand-computed expected outputs into a queue tagged with the
// cycle in which they must appear; a monitor compares on the falling edge.
// ----------------------------------------------------------------------------
module tb_calc_entry_seq;
    localparam int DIGITS = 2;

    typedef struct {
        int         cyc;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [1:0] da;
        logic [1:0] db;
        logic [2:0] st;
        logic       req;
        logic       err;
    } exp_t;

    logic clk;
    logic reset_n;
    int   cyc;
    int   total;
    int   bad;
    exp_t q[$];

    calc_entry_seq_if #(.DIGITS(DIGITS)) bus ();

    calc_entry_seq #(.DIGITS(DIGITS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index used to align expectations with edges.
    always @(posedge clk) cyc <= cyc + 1;

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic rst, input logic v, input logic [4:0] code,
                        input logic ack, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op, input logic [1:0] da,
                        input logic [1:0] db, input logic [2:0] st,
                        input logic req, input logic err);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n        = rst;
        bus.key_valid  = v;
        bus.key_code   = code;
        bus.result_ack = ack;
        e.cyc = cyc + 1;
        e.a = a; e.b = b; e.op = op; e.da = da; e.db = db;
        e.st = st; e.req = req; e.err = err;
        q.push_back(e);
    endtask

    // Scoreboard monitor: compare whenever an expectation is due.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                total++;
                if (e.cyc != cyc ||
                    bus.operand_a !== e.a || bus.operand_b !== e.b ||
                    bus.op !== e.op || bus.digits_a !== e.da ||
                    bus.digits_b !== e.db || bus.state !== e.st ||
                    bus.result_req !== e.req || bus.key_err !== e.err) begin
                    bad++;
                    $display("FAIL outputs@cyc%0d: got a=%h b=%h op=%0d da=%0d db=%0d st=%0d req=%b err=%b, need a=%h b=%h op=%0d da=%0d db=%0d st=%0d req=%b err=%b",
                             e.cyc, bus.operand_a, bus.operand_b, bus.op,
                             bus.digits_a, bus.digits_b, bus.state,
                             bus.result_req, bus.key_err, e.a, e.b, e.op,
                             e.da, e.db, e.st, e.req, e.err);
                end
            end
        end
    end

    initial begin
        cyc = 0; total = 0; bad = 0;
        reset_n = 1'b0;
        bus.key_valid = 1'b0; bus.key_code = 5'd0; bus.result_ack = 1'b0;

        //    rst   v     code   ack   a      b      op    da    db    st    req   err
        step(1'b0, 1'b0, 5'd0,  1'b0, 8'h00, 8'h00, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 5'd0,  1'b0, 8'h00, 8'h00, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0);
        // normal flow 1 2 + 3 4 =
        step(1'b1, 1'b1, 5'd1,  1'b0, 8'h01, 8'h00, 2'd0, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd2,  1'b0, 8'h12, 8'h00, 2'd0, 2'd2, 2'd0, 3'd1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd11, 1'b0, 8'h12, 8'h00, 2'd0, 2'd2, 2'd0, 3'd2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd3,  1'b0, 8'h12, 8'h03, 2'd0, 2'd2, 2'd1, 3'd2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd4,  1'b0, 8'h12, 8'h34, 2'd0, 2'd2, 2'd2, 3'd2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd15, 1'b0, 8'h12, 8'h34, 2'd0, 2'd2, 2'd2, 3'd3, 1'b1, 1'b0);
        step(1'b1, 1'b0, 5'd0,  1'b0, 8'h12, 8'h34, 2'd0, 2'd2, 2'd2, 3'd3, 1'b1, 1'b0);
        step(1'b1, 1'b0, 5'd0,  1'b1, 8'h12, 8'h34, 2'd0, 2'd2, 2'd2, 3'd0, 1'b0, 1'b0);
        // post-result: operator rejected, then digit starts afresh
        step(1'b1, 1'b1, 5'd12, 1'b0, 8'h12, 8'h34, 2'd0, 2'd2, 2'd2, 3'd0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 5'd4,  1'b0, 8'h04, 8'h00, 2'd0, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd16, 1'b0, 8'h00, 8'h00, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0);
        // full operand 5 0, then digit and enter rejected in WAIT_OP
        step(1'b1, 1'b1, 5'd5,  1'b0, 8'h05, 8'h00, 2'd0, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd10, 1'b0, 8'h50, 8'h00, 2'd0, 2'd2, 2'd0, 3'd1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd7,  1'b0, 8'h50, 8'h00, 2'd0, 2'd2, 2'd0, 3'd1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 5'd15, 1'b0, 8'h50, 8'h00, 2'd0, 2'd2, 2'd0, 3'd1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 5'd0,  1'b0, 8'h50, 8'h00, 2'd0, 2'd2, 2'd0, 3'd1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 5'd0,  1'b1, 8'h50, 8'h00, 2'd0, 2'd2, 2'd0, 3'd1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd16, 1'b0, 8'h00, 8'h00, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0);
        // early operator, empty-B enter, operator in B, full B
        step(1'b1, 1'b1, 5'd9,  1'b0, 8'h09, 8'h00, 2'd0, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd13, 1'b0, 8'h09, 8'h00, 2'd2, 2'd1, 2'd0, 3'd2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd15, 1'b0, 8'h09, 8'h00, 2'd2, 2'd1, 2'd0, 3'd2, 1'b0, 1'b1);
        step(1'b1, 1'b1, 5'd11, 1'b0, 8'h09, 8'h00, 2'd2, 2'd1, 2'd0, 3'd2, 1'b0, 1'b1);
        step(1'b1, 1'b1, 5'd1,  1'b0, 8'h09, 8'h01, 2'd2, 2'd1, 2'd1, 3'd2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd2,  1'b0, 8'h09, 8'h12, 2'd2, 2'd1, 2'd2, 3'd2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd3,  1'b0, 8'h09, 8'h12, 2'd2, 2'd1, 2'd2, 3'd2, 1'b0, 1'b1);
        step(1'b1, 1'b1, 5'd15, 1'b0, 8'h09, 8'h12, 2'd2, 2'd1, 2'd2, 3'd3, 1'b1, 1'b0);
        // clear together with ack: clear wins
        step(1'b1, 1'b1, 5'd16, 1'b1, 8'h00, 8'h00, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0);
        // ack together with a non-clear key
        step(1'b1, 1'b1, 5'd1,  1'b0, 8'h01, 8'h00, 2'd0, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd11, 1'b0, 8'h01, 8'h00, 2'd0, 2'd1, 2'd0, 3'd2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd2,  1'b0, 8'h01, 8'h02, 2'd0, 2'd1, 2'd1, 3'd2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd15, 1'b0, 8'h01, 8'h02, 2'd0, 2'd1, 2'd1, 3'd3, 1'b1, 1'b0);
        step(1'b1, 1'b1, 5'd5,  1'b1, 8'h01, 8'h02, 2'd0, 2'd1, 2'd1, 3'd0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 5'd5,  1'b0, 8'h05, 8'h00, 2'd0, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0);
        // illegal codes, strobe-low garbage, stray ack
        step(1'b1, 1'b1, 5'd0,  1'b0, 8'h05, 8'h00, 2'd0, 2'd1, 2'd0, 3'd0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 5'd20, 1'b0, 8'h05, 8'h00, 2'd0, 2'd1, 2'd0, 3'd0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 5'd3,  1'b1, 8'h05, 8'h00, 2'd0, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd3,  1'b1, 8'h53, 8'h00, 2'd0, 2'd2, 2'd0, 3'd1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd16, 1'b0, 8'h00, 8'h00, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0);
        // backspace (key 17)
        step(1'b1, 1'b1, 5'd1,  1'b0, 8'h01, 8'h00, 2'd0, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd2,  1'b0, 8'h12, 8'h00, 2'd0, 2'd2, 2'd0, 3'd1, 1'b0, 1'b0);
`ifdef CALC_BACKSPACE_EN
        step(1'b1, 1'b1, 5'd17, 1'b0, 8'h01, 8'h00, 2'd0, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0);
`else
        step(1'b1, 1'b1, 5'd17, 1'b0, 8'h12, 8'h00, 2'd0, 2'd2, 2'd0, 3'd1, 1'b0, 1'b1);
`endif
        // reset in the middle of an operation beats a key
        step(1'b0, 1'b1, 5'd3,  1'b0, 8'h00, 8'h00, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 5'd0,  1'b0, 8'h00, 8'h00, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, need 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/calc_entry_seq.md
# calc_entry_seq

Clocked, parametrised keypad-entry sequencer for the calculator datapath. It turns one-cycle key strobes into registered BCD operands A and B, an operator code, and a result request, using a request/acknowledge handshake. Compared with the earlier combinational button verifier, it:

- supports any operand length;
- lets the user enter an operator before an operand is full;
- rejects illegal keys explicitly instead of silently ignoring them.

It sits between the key debouncer/encoder and the arithmetic/display units.

## Interface
Parameters:
- DIGITS, default 2: BCD digits per operand. Legal range 1..8.
- CW, default $clog2(DIGITS+1): width of the digit counters. Derived; never overridden.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- key_valid  input  1  one-cycle strobe; key_code is meaningful only while it is high.
- key_code  input  5  key value:
  - 1..9 are digits 1..9; 10 is digit 0.
  - 11..14 are operators +, -, *, /.
  - 15 is enter; 16 is clear; 17 is backspace (see Configuration).
  - All other codes are illegal.
- result_ack  input  1  arithmetic unit has taken the operands.
- operand_a  output  4*DIGITS  BCD operand A; newest digit in the low nibble.
- operand_b  output  4*DIGITS  BCD operand B; same format as A.
- op  output  2  operator: key_code minus 11.
- digits_a  output  CW  number of digits entered in A.
- digits_b  output  CW  number of digits entered in B.
- state  output  3  000 ENTER_A, 001 WAIT_OP, 010 ENTER_B, 011 RESULT.
- result_req  output  1  high while RESULT is waiting for result_ack.
- key_err  output  1  one-cycle pulse when a strobed key is rejected.

## Operation
- Reset values: every output is 0 and the state is ENTER_A. The internal fresh flag is 0.
- Digit entry shifts the operand left one nibble and loads the new digit into the low nibble. The digit count increments; the operand width never overflows because entry stops at DIGITS.
- ENTER_A:
  - A digit key appends to A. When digits_a reaches DIGITS, the state moves to WAIT_OP.
  - An operator key with digits_a ≥ 1 latches op and moves to ENTER_B (early operator).
  - An operator key with digits_a = 0 raises key_err.
  - Enter raises key_err.
- WAIT_OP:
  - An operator key latches op and moves to ENTER_B.
  - A digit key or enter raises key_err; registers are unchanged.
- ENTER_B:
  - A digit key appends to B while digits_b < DIGITS. When B is full, a further digit raises key_err.
  - Enter with digits_b ≥ 1 moves to RESULT and asserts result_req.
  - Enter with digits_b = 0 raises key_err.
  - An operator key raises key_err.
- RESULT:
  - result_req stays high until result_ack is sampled high. The state then returns to ENTER_A with fresh = 1; operands, op and the digit counts are held for display.
  - Every key except clear raises key_err.
- fresh = 1 in ENTER_A:
  - The first digit key clears operand_b, op and digits_b. It loads operand_a with that single digit, sets digits_a = 1 and clears fresh.
  - Operator, enter and backspace keys raise key_err.
- Clear (16), in any state including RESULT: every output and fresh go to reset values on the next edge. Clear never raises key_err.
- Illegal codes (0, 18..31, and 17 without the macro) raise key_err and change nothing else.
- When key_valid is low, nothing changes and key_err is 0.
- result_ack is ignored outside RESULT.

## Timing
- All outputs are registered. A key sampled at edge N is visible in the outputs after edge N.
- result_req rises at the same edge that enters RESULT, and falls at the edge where result_ack is sampled high.
- If result_ack and a clear key arrive in the same cycle, clear wins; the result is the reset state.
- If result_ack and a non-clear key arrive in the same cycle, the ack is taken and the key is rejected with key_err.
- reset_n low takes priority over everything, including mid-operation. The block is in its reset state at the next edge.
- Throughput: one key per cycle; back-to-back strobes are legal.

## Configuration
- Macro CALC_BACKSPACE_EN.
- With the macro defined, key 17 is backspace:
  - ENTER_A or ENTER_B with count ≥ 1: shift the operand right one nibble, zero-fill the top nibble and decrement the count.
  - WAIT_OP: return to ENTER_A and remove A's last digit.
  - ENTER_B with digits_b = 0: return to WAIT_OP and clear op.
  - ENTER_A with digits_a = 0, RESULT, or fresh = 1: key_err.
- Without the macro, key 17 is illegal and raises key_err.

## Test plan
All scenarios use DIGITS = 2.
- Normal flow: keys 1, 2, 11, 3, 4, 15 → operand_a = 0x12, op = 0, operand_b = 0x34, state = 011, result_req = 1. After result_ack → state = 000, result_req = 0, values held.
- Full operand: keys 5, 10 → operand_a = 0x50, state = 001. Key 7 → key_err pulse; operand_a stays 0x50.
- Early operator and empty B: keys 9, 13 → operand_a = 0x09, op = 2, state = 010. Key 15 → key_err, state stays 010.
- Clear with ack: in RESULT, key 16 and result_ack in the same cycle → all outputs 0, state = 000.
- Post-result entry: after ack, key 4 → operand_a = 0x04, digits_a = 1, operand_b = 0, op = 0. A key 12 entered before the 4 → key_err.
- Backspace: keys 1, 2, 17 → with CALC_BACKSPACE_EN, operand_a = 0x01, digits_a = 1, state = 000. Without the macro → key_err, operand_a = 0x12.
